// File: rtl/window_frame_reader_pkg.sv
// Shared definitions for the window RAM reader: FSM state encoding and frame sizing.
package window_frame_reader_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic int frame_len(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/window_frame_reader_skid_fifo2.sv
// Two-entry FIFO that absorbs RAM read latency and downstream backpressure.
module skid_fifo2
    import window_frame_reader_pkg::*;
#(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         wr_sel;
    logic         rd_sel;

    assign head = rd_sel ? slot1 : slot0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_sel) slot1 <= push_data;
                else        slot0 <= push_data;
                wr_sel <= ~wr_sel;
            end
            if (pop) rd_sel <= ~rd_sel;
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/window_frame_reader.sv
// Reads one windowed frame out of W_RAM in FFT input order and streams it over valid/ready.
module window_frame_reader
    import window_frame_reader_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int BIT_REV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [15:0]       frame_cnt
);

    localparam int FRAME_N = frame_len(ADDR_W);
    localparam logic [ADDR_W:0] LAST_K = (ADDR_W+1)'(FRAME_N - 1);

    logic [1:0]               state;
    logic [ADDR_W:0]          issued;
    logic [ADDR_W:0]          sent;
    logic                     inflight;
    logic [1:0]               buf_count;
    logic [2:0]               occupancy;
    logic                     pop;
    logic [ADDR_W-1:0]        k_lo;
    logic [ADDR_W-1:0]        k_rev;
    logic [ADDR_W-1:0]        push_index;
    logic [DATA_W+ADDR_W-1:0] head_word;

    assign k_lo = issued[ADDR_W-1:0];

    for (genvar g = 0; g < ADDR_W; g++) begin : g_rev
        assign k_rev[g] = k_lo[ADDR_W-1-g];
    end

    assign ram_addr = (BIT_REV != 0) ? k_rev : k_lo;

    // Slots already committed next cycle: stored words plus the word on its way back, minus the one leaving.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign ram_en    = (state == FETCH) && !issued[ADDR_W] && (occupancy < 3'd2);

    // issued has already advanced past the read that is returning now.
    assign push_index = k_lo - ADDR_W'(1);

    assign out_valid = (buf_count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = head_word[DATA_W+ADDR_W-1:ADDR_W];
    assign out_index = head_word[ADDR_W-1:0];
    assign out_last  = out_valid && (out_index == {ADDR_W{1'b1}});
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    skid_fifo2 #(
        .W(DATA_W + ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data({ram_dout, push_index}),
        .pop      (pop),
        .head     (head_word),
        .count    (buf_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            issued    <= '0;
            sent      <= '0;
            inflight  <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            inflight <= ram_en;
            if (ram_en) issued <= issued + (ADDR_W+1)'(1);
            if (pop)    sent   <= sent + (ADDR_W+1)'(1);
            case (state)
                IDLE:  if (start) state <= FETCH;
                FETCH: if (ram_en && (issued == LAST_K)) state <= DRAIN;
                DRAIN: if (pop && (sent == LAST_K)) state <= DONE;
                DONE: begin
                    state     <= IDLE;
                    frame_cnt <= frame_cnt + 16'd1;
                    issued    <= '0;
                    sent      <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
